ysyx_22040386_hazard_ctrl: RTL and testbench
============================================

# ysyx_22040386_hazard_ctrl

Pipeline hazard and stall controller for the 5-stage core. It sits beside the forwarding unit and sequences the pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB). It inserts load-use bubbles, freezes the front of the pipe on data-memory wait, and flushes wrong-path instructions on an EX-stage redirect. It drains an in-flight instruction fetch after a redirect and counts stall cycles with a memory-wait watchdog.

## Interface
Parameters:
- CNT_W, 32, width of the stall-cycle counter (saturating).
- TIMEOUT, 255, maximum consecutive memory-wait cycles before `o_hz_timeout` is set.

Ports:
- i_clk  in  1  core clock; all state updates on rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_hz_ID_EX_MemRead  in  1  instruction in EX is a load.
- i_hz_ID_EX_reg_wr_addr  in  5  destination register of the instruction in EX.
- i_hz_IF_ID_reg_rd_addr1 / i_hz_IF_ID_reg_rd_addr2  in  5 each  source registers of the instruction in ID.
- i_hz_IF_ID_use1 / i_hz_IF_ID_use2  in  1 each  the instruction in ID actually reads rs1 / rs2.
- i_hz_EX_redirect  in  1  EX resolved a taken branch, jump or mispredict.
- i_hz_imem_valid  in  1  fetch returns a valid instruction this cycle.
- i_hz_MEM_req  in  1  the instruction in MEM accesses data memory.
- i_hz_dmem_ready  in  1  data memory completes the access this cycle.
- o_hz_pc_we  out  1  PC register write enable.
- o_hz_pc_sel_redirect  out  1  PC loads the EX redirect target.
- o_hz_IF_ID_en / o_hz_IF_ID_flush  out  1 each  IF/ID hold control / bubble insert.
- o_hz_ID_EX_en / o_hz_ID_EX_flush  out  1 each  ID/EX hold control / bubble insert.
- o_hz_EX_MEM_en  out  1  EX/MEM enable.
- o_hz_MEM_WB_flush  out  1  insert bubble into MEM/WB.
- o_hz_stall_cnt  out  CNT_W  total cycles with `o_hz_pc_we`=0 since reset, saturating.
- o_hz_timeout  out  1  sticky; memory wait exceeded TIMEOUT.

## Operation
- States:
  - RUN: normal operation.
  - DRAIN: discarding a stale fetch.
- Conditions:
  - mem_stall = i_hz_MEM_req & !i_hz_dmem_ready.
  - load_use = i_hz_ID_EX_MemRead & wr_addr≠0 & ((use1 & rd1==wr) | (use2 & rd2==wr)).
- Defaults (all signals not listed in a condition): all enables 1, all flushes 0, pc_we=1, pc_sel_redirect=0.
- Conditions are evaluated in the following priority order; the highest applicable one wins:
  1. mem_stall (any state): pc_we=0, IF_ID_en=0, ID_EX_en=0, EX_MEM_en=0, MEM_WB_flush=1. The redirect is not acted on, because EX is frozen and the redirect is re-presented later.
  2. i_hz_EX_redirect: pc_we=1, pc_sel_redirect=1, IF_ID_flush=1, ID_EX_flush=1. If i_hz_imem_valid=0 in RUN, go to DRAIN.
  3. DRAIN without redirect: pc_we=0, IF_ID_flush=1. On i_hz_imem_valid=1, drop the returned instruction (IF_ID_flush=1) and go to RUN.
  4. load_use: pc_we=0, IF_ID_en=0, ID_EX_flush=1. This gives exactly one bubble.
  5. RUN with i_hz_imem_valid=0: pc_we=0, IF_ID_flush=1.
- Stall counter: increments each cycle with pc_we=0 and i_rst=0; it holds at 2^CNT_W−1.
- Watchdog: an 8-bit-or-wider wait counter increments while mem_stall=1 and clears when mem_stall=0. When the count reaches TIMEOUT, o_hz_timeout←1 and stays set until reset. The pipeline keeps stalling; the timeout is a flag only.

## Timing
- All pipeline-control outputs are combinational from the inputs and the current state, so a stall takes effect in the same cycle it is detected.
- State, stall counter, wait counter and the timeout flag are registered.
- Reset (asynchronous, applies immediately):
  - state=RUN, counters=0, o_hz_timeout=0.
  - While i_rst=1, outputs are forced to: pc_we=0, all *_en=0, all *_flush=1, pc_sel_redirect=0.
- Load-use costs one cycle. In the following cycle the load has moved to MEM and the forwarding unit supplies the data.
- Redirect costs two bubbles when the fetch is valid. Each DRAIN cycle adds one more bubble.
- Redirect and load_use in the same cycle: redirect wins and load_use is ignored, because the ID instruction is flushed.
- Redirect arriving in DRAIN: take the new target, stay in DRAIN if imem_valid=0, otherwise go to RUN.
- mem_stall in DRAIN: the state is held and the imem response is not consumed that cycle.
- Reset asserted mid-DRAIN: go to RUN immediately.

## Test plan
- Reset: hold i_rst=1 for 3 cycles. Require all *_en=0, all flushes=1, stall_cnt=0, timeout=0. After release with imem_valid=1 and no hazards, require all outputs at their defaults.
- Load-use: MemRead=1, wr=5, rd1=5, use1=1. Require exactly one cycle of pc_we=0, IF_ID_en=0, ID_EX_flush=1, then defaults; stall_cnt=1. Repeat with wr=0 and require no stall.
- Redirect with valid fetch: redirect=1, imem_valid=1. Require pc_sel_redirect=1, IF_ID_flush=1, ID_EX_flush=1 for one cycle, state stays RUN.
- Redirect with pending fetch: redirect=1, imem_valid=0, then imem_valid=0 for 2 more cycles, then 1. Require IF_ID_flush=1 for all 4 cycles, pc_we=0 in the 3 DRAIN cycles, RUN afterwards.
- Memory wait overriding redirect: MEM_req=1, dmem_ready=0 for 4 cycles with redirect=1. Require pc_sel_redirect=0, EX_MEM_en=0, MEM_WB_flush=1 in all 4 cycles. When dmem_ready=1, the redirect is taken in that cycle.
- Watchdog and saturation: with TIMEOUT=3, hold mem_stall for 5 cycles. Require timeout=1 from the cycle after the third wait cycle and kept set after the stall clears. With CNT_W=2, hold stalls for 6 cycles and require stall_cnt=3.

Source files
------------

// File: rtl/ysyx_22040386_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage pipe: load-use bubbles, data-memory
// freeze, redirect flush with stale-fetch drain, stall counter and wait watchdog.
module ysyx_22040386_hazard_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_hz_ID_EX_MemRead,
  input  logic [4:0]       i_hz_ID_EX_reg_wr_addr,
  input  logic [4:0]       i_hz_IF_ID_reg_rd_addr1,
  input  logic [4:0]       i_hz_IF_ID_reg_rd_addr2,
  input  logic             i_hz_IF_ID_use1,
  input  logic             i_hz_IF_ID_use2,
  input  logic             i_hz_EX_redirect,
  input  logic             i_hz_imem_valid,
  input  logic             i_hz_MEM_req,
  input  logic             i_hz_dmem_ready,
  output logic             o_hz_pc_we,
  output logic             o_hz_pc_sel_redirect,
  output logic             o_hz_IF_ID_en,
  output logic             o_hz_IF_ID_flush,
  output logic             o_hz_ID_EX_en,
  output logic             o_hz_ID_EX_flush,
  output logic             o_hz_EX_MEM_en,
  output logic             o_hz_MEM_WB_flush,
  output logic [CNT_W-1:0] o_hz_stall_cnt,
  output logic             o_hz_timeout
);

  localparam int WAIT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                timeout_q, timeout_d;
  logic                mem_stall;
  logic                load_use;
  logic [31:0]         wait_next;

  assign mem_stall = i_hz_MEM_req & ~i_hz_dmem_ready;
  assign load_use  = i_hz_ID_EX_MemRead & (i_hz_ID_EX_reg_wr_addr != 5'd0) &
                     ((i_hz_IF_ID_use1 & (i_hz_IF_ID_reg_rd_addr1 == i_hz_ID_EX_reg_wr_addr)) |
                      (i_hz_IF_ID_use2 & (i_hz_IF_ID_reg_rd_addr2 == i_hz_ID_EX_reg_wr_addr)));

  always_comb begin
    o_hz_pc_we           = 1'b1;
    o_hz_pc_sel_redirect = 1'b0;
    o_hz_IF_ID_en        = 1'b1;
    o_hz_IF_ID_flush     = 1'b0;
    o_hz_ID_EX_en        = 1'b1;
    o_hz_ID_EX_flush     = 1'b0;
    o_hz_EX_MEM_en       = 1'b1;
    o_hz_MEM_WB_flush    = 1'b0;
    state_d              = state_q;
    if (i_rst) begin
      o_hz_pc_we        = 1'b0;
      o_hz_IF_ID_en     = 1'b0;
      o_hz_IF_ID_flush  = 1'b1;
      o_hz_ID_EX_en     = 1'b0;
      o_hz_ID_EX_flush  = 1'b1;
      o_hz_EX_MEM_en    = 1'b0;
      o_hz_MEM_WB_flush = 1'b1;
      state_d           = RUN;
    end else if (mem_stall) begin
      // EX is frozen, so a pending redirect will be presented again later.
      o_hz_pc_we        = 1'b0;
      o_hz_IF_ID_en     = 1'b0;
      o_hz_ID_EX_en     = 1'b0;
      o_hz_EX_MEM_en    = 1'b0;
      o_hz_MEM_WB_flush = 1'b1;
    end else if (i_hz_EX_redirect) begin
      o_hz_pc_sel_redirect = 1'b1;
      o_hz_IF_ID_flush     = 1'b1;
      o_hz_ID_EX_flush     = 1'b1;
      state_d              = i_hz_imem_valid ? RUN : DRAIN;
    end else if (state_q == DRAIN) begin
      o_hz_pc_we       = 1'b0;
      o_hz_IF_ID_flush = 1'b1;
      if (i_hz_imem_valid) state_d = RUN;
    end else if (load_use) begin
      o_hz_pc_we       = 1'b0;
      o_hz_IF_ID_en    = 1'b0;
      o_hz_ID_EX_flush = 1'b1;
    end else if (!i_hz_imem_valid) begin
      o_hz_pc_we       = 1'b0;
      o_hz_IF_ID_flush = 1'b1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!o_hz_pc_we && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    wait_d = '0;
    if (mem_stall)
      wait_d = (wait_q == {WAIT_W{1'b1}}) ? wait_q : wait_q + {{(WAIT_W-1){1'b0}}, 1'b1};
    // Flag raised at the end of the wait cycle that brings the count to TIMEOUT.
    wait_next = 32'(wait_q) + 32'd1;
    timeout_d = timeout_q | (mem_stall & (wait_next >= 32'(TIMEOUT)));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
      wait_q      <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      wait_q      <= wait_d;
      timeout_q   <= timeout_d;
    end
  end

  assign o_hz_stall_cnt = stall_cnt_q;
  assign o_hz_timeout   = timeout_q;

endmodule

// File: tb/tb_ysyx_22040386_hazard_ctrl.sv
// Directed bench for the hazard controller, built with a 2-bit stall counter
// and TIMEOUT=3 so saturation and the watchdog are reachable quickly.
module tb_ysyx_22040386_hazard_ctrl;

  localparam int CNT_W   = 2;
  localparam int TIMEOUT = 3;

  // Control vector: {pc_we, pc_sel_redirect, IF_ID_en, IF_ID_flush,
  //                  ID_EX_en, ID_EX_flush, EX_MEM_en, MEM_WB_flush}
  localparam logic [7:0] C_DEF   = 8'b1010_1010;
  localparam logic [7:0] C_RST   = 8'b0001_0101;
  localparam logic [7:0] C_MEM   = 8'b0000_0001;
  localparam logic [7:0] C_REDIR = 8'b1111_1110;
  localparam logic [7:0] C_BUB   = 8'b0011_1010;
  localparam logic [7:0] C_LU    = 8'b0000_1110;

  logic             clk, rst;
  logic             mr, u1, u2, redir, iv, mreq, dr;
  logic [4:0]       wr, rd1, rd2;
  logic             pc_we, pc_sel, ifid_en, ifid_fl, idex_en, idex_fl, exmem_en, memwb_fl;
  logic [CNT_W-1:0] stall_cnt;
  logic             timeout;
  logic [7:0]       ctl;

  int checks = 0;
  int errors = 0;

  ysyx_22040386_hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .i_clk                   (clk),
    .i_rst                   (rst),
    .i_hz_ID_EX_MemRead      (mr),
    .i_hz_ID_EX_reg_wr_addr  (wr),
    .i_hz_IF_ID_reg_rd_addr1 (rd1),
    .i_hz_IF_ID_reg_rd_addr2 (rd2),
    .i_hz_IF_ID_use1         (u1),
    .i_hz_IF_ID_use2         (u2),
    .i_hz_EX_redirect        (redir),
    .i_hz_imem_valid         (iv),
    .i_hz_MEM_req            (mreq),
    .i_hz_dmem_ready         (dr),
    .o_hz_pc_we              (pc_we),
    .o_hz_pc_sel_redirect    (pc_sel),
    .o_hz_IF_ID_en           (ifid_en),
    .o_hz_IF_ID_flush        (ifid_fl),
    .o_hz_ID_EX_en           (idex_en),
    .o_hz_ID_EX_flush        (idex_fl),
    .o_hz_EX_MEM_en          (exmem_en),
    .o_hz_MEM_WB_flush       (memwb_fl),
    .o_hz_stall_cnt          (stall_cnt),
    .o_hz_timeout            (timeout)
  );

  assign ctl = {pc_we, pc_sel, ifid_en, ifid_fl, idex_en, idex_fl, exmem_en, memwb_fl};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge, apply one input vector, let it settle.
  task automatic drive(input logic r, input logic m, input logic [4:0] w,
                       input logic [4:0] a1, input logic [4:0] a2,
                       input logic s1, input logic s2, input logic rd_i,
                       input logic v, input logic q, input logic y);
    @(negedge clk);
    rst = r; mr = m; wr = w; rd1 = a1; rd2 = a2; u1 = s1; u2 = s2;
    redir = rd_i; iv = v; mreq = q; dr = y;
    #1;
  endtask

  task automatic idle(input logic v);
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, v, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic redirect(input logic v);
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, v, 1'b0, 1'b1);
  endtask

  task automatic memwait(input logic rd_i);
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, rd_i, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b1; mr = 1'b0; wr = '0; rd1 = '0; rd2 = '0; u1 = 1'b0; u2 = 1'b0;
    redir = 1'b0; iv = 1'b1; mreq = 1'b0; dr = 1'b1;

    // Reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      do_reset();
      check("rst_ctl", 32'(ctl), 32'(C_RST));
      check("rst_cnt", 32'(stall_cnt), 32'd0);
      check("rst_to", 32'(timeout), 32'd0);
    end
    idle(1'b1);
    check("post_rst_ctl", 32'(ctl), 32'(C_DEF));

    // Load-use through rs1: exactly one bubble
    drive(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("lu_rs1", 32'(ctl), 32'(C_LU));
    idle(1'b1);
    check("lu_after", 32'(ctl), 32'(C_DEF));
    check("lu_cnt", 32'(stall_cnt), 32'd1);
    // x0 destination never stalls
    drive(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    check("lu_x0", 32'(ctl), 32'(C_DEF));
    // Matching rs1 not used, rs2 differs
    drive(1'b0, 1'b1, 5'd7, 5'd7, 5'd9, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    check("lu_nouse", 32'(ctl), 32'(C_DEF));
    // Load-use through rs2
    drive(1'b0, 1'b1, 5'd7, 5'd1, 5'd7, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    check("lu_rs2", 32'(ctl), 32'(C_LU));
    // Not a load: no stall
    drive(1'b0, 1'b0, 5'd7, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    check("lu_noload", 32'(ctl), 32'(C_DEF));
    check("lu_cnt2", 32'(stall_cnt), 32'd2);

    // Redirect with valid fetch, concurrent load-use ignored
    drive(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    check("redir_v", 32'(ctl), 32'(C_REDIR));
    idle(1'b1);
    check("redir_v_run", 32'(ctl), 32'(C_DEF));
    check("redir_v_cnt", 32'(stall_cnt), 32'd2);

    // Asynchronous reset takes effect immediately
    do_reset();
    check("arst_cnt", 32'(stall_cnt), 32'd0);

    // Redirect with pending fetch: drain three cycles, then RUN
    redirect(1'b0);
    check("drain_redir", 32'(ctl), 32'(C_REDIR));
    idle(1'b0);
    check("drain1", 32'(ctl), 32'(C_BUB));
    idle(1'b0);
    check("drain2", 32'(ctl), 32'(C_BUB));
    idle(1'b1);
    check("drain3_drop", 32'(ctl), 32'(C_BUB));
    idle(1'b1);
    check("drain_run", 32'(ctl), 32'(C_DEF));
    check("drain_cnt", 32'(stall_cnt), 32'd3);
    // Fetch bubble in RUN; counter must saturate at 3
    idle(1'b0);
    check("run_nofetch", 32'(ctl), 32'(C_BUB));
    idle(1'b1);
    check("cnt_sat", 32'(stall_cnt), 32'd3);

    // Redirect while draining
    do_reset();
    redirect(1'b0);
    redirect(1'b0);
    check("dr_redir0", 32'(ctl), 32'(C_REDIR));
    idle(1'b0);
    check("dr_still", 32'(ctl), 32'(C_BUB));
    redirect(1'b1);
    check("dr_redir1", 32'(ctl), 32'(C_REDIR));
    idle(1'b1);
    check("dr_back_run", 32'(ctl), 32'(C_DEF));

    // Memory stall inside DRAIN holds the state
    redirect(1'b0);
    memwait(1'b0);
    check("dr_mem", 32'(ctl), 32'(C_MEM));
    idle(1'b1);
    check("dr_mem_held", 32'(ctl), 32'(C_BUB));
    idle(1'b1);
    check("dr_mem_run", 32'(ctl), 32'(C_DEF));

    // Reset mid-DRAIN returns to RUN
    redirect(1'b0);
    do_reset();
    check("dr_rst_ctl", 32'(ctl), 32'(C_RST));
    idle(1'b1);
    check("dr_rst_run", 32'(ctl), 32'(C_DEF));

    // Memory wait overrides redirect; watchdog fires after third wait cycle
    do_reset();
    for (int i = 0; i < 4; i++) begin
      memwait(1'b1);
      check("mw_ctl", 32'(ctl), 32'(C_MEM));
      check("mw_to", 32'(timeout), (i >= 3) ? 32'd1 : 32'd0);
    end
    redirect(1'b1);
    check("mw_release", 32'(ctl), 32'(C_REDIR));
    check("mw_cnt_sat", 32'(stall_cnt), 32'd3);
    idle(1'b1);
    check("to_sticky", 32'(timeout), 32'd1);

    // Wait counter clears when the stall breaks
    do_reset();
    memwait(1'b0);
    memwait(1'b0);
    idle(1'b1);
    memwait(1'b0);
    memwait(1'b0);
    idle(1'b1);
    check("wd_clear", 32'(timeout), 32'd0);
    memwait(1'b0);
    memwait(1'b0);
    memwait(1'b0);
    idle(1'b1);
    check("wd_fire", 32'(timeout), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
